// File: rtl/mrna_iso_valve_sequencer_if.sv
// Host command and pneumatic control bundle for the 4-lane mRNA isolation chip.
// The pause line exists only when MRNAISO_SEQ_PAUSE_EN is defined.
interface mrna_iso_valve_sequencer_if;
    logic       start;
    logic       abort;
    logic [3:0] lane_mask;
`ifdef MRNAISO_SEQ_PAUSE_EN
    logic       pause;
`endif
    logic       busy;
    logic       done;
    logic [2:0] step;
    logic [3:0] cells_in_ctl;
    logic [3:0] cells_out_ctl;
    logic [3:0] collect_ctl;
    logic       lysis_in_ctl;
    logic       lysis_waste_ctl;
    logic       beads_in_ctl;
    logic       bead_waste_ctl;
    logic       push_ctl;
    logic       sep_ctl;
    logic       sieve_ctl;
    logic       waste_ctl;
    logic       pump_1;
    logic       pump_2;
    logic       pump_3;

    // Host side issues commands and observes the valve lines.
    modport master (
`ifdef MRNAISO_SEQ_PAUSE_EN
        output pause,
`endif
        output start, abort, lane_mask,
        input  busy, done, step,
        input  cells_in_ctl, cells_out_ctl, collect_ctl,
        input  lysis_in_ctl, lysis_waste_ctl, beads_in_ctl, bead_waste_ctl,
        input  push_ctl, sep_ctl, sieve_ctl, waste_ctl,
        input  pump_1, pump_2, pump_3
    );

    // Sequencer side takes commands and drives the valve lines.
    modport slave (
`ifdef MRNAISO_SEQ_PAUSE_EN
        input  pause,
`endif
        input  start, abort, lane_mask,
        output busy, done, step,
        output cells_in_ctl, cells_out_ctl, collect_ctl,
        output lysis_in_ctl, lysis_waste_ctl, beads_in_ctl, bead_waste_ctl,
        output push_ctl, sep_ctl, sieve_ctl, waste_ctl,
        output pump_1, pump_2, pump_3
    );
endinterface

// File: rtl/mrna_iso_valve_sequencer.sv
// Valve sequencer for the mRNA isolation chip: load, lyse/mix, capture, wash, elute.
// Optional freeze input enabled by defining MRNAISO_SEQ_PAUSE_EN.
module mrna_iso_valve_sequencer #(
    parameter logic [15:0] STEP_TICKS = 16'd1000,
    parameter logic [15:0] PUMP_TICKS = 16'd50,
    parameter logic [15:0] MIX_CYCLES = 16'd20
) (
    input logic                          clk,
    input logic                          rst,
    mrna_iso_valve_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_CELLS = 3'd1,
        LOAD_LYSIS = 3'd2,
        MIX        = 3'd3,
        LOAD_BEADS = 3'd4,
        CAPTURE    = 3'd5,
        WASH       = 3'd6,
        ELUTE      = 3'd7
    } state_t;

    typedef struct packed {
        logic [3:0] cells_in;
        logic [3:0] cells_out;
        logic [3:0] collect;
        logic       lysis_in;
        logic       lysis_waste;
        logic       beads_in;
        logic       bead_waste;
        logic       push;
        logic       sep;
        logic       sieve;
        logic       waste;
        logic [2:0] pumps;
    } valves_t;

    state_t      state;
    valves_t     valves;
    logic [15:0] tick_cnt;
    logic [15:0] pump_cnt;
    logic [15:0] rot_cnt;
    logic [1:0]  phase;
    logic [3:0]  mask;
    logic        busy_r;
    logic        done_r;

    logic        hold;
    logic        pump_wrap;
    logic [1:0]  phase_next;
    logic        step_last;
    state_t      state_after;

    // A 0 on a pump line opens that chamber; the closed pair pushes fluid around the ring.
    function automatic logic [2:0] pump_rotation(input logic [1:0] ph);
        case (ph)
            2'd0:    pump_rotation = 3'b011;
            2'd1:    pump_rotation = 3'b101;
            default: pump_rotation = 3'b110;
        endcase
    endfunction

    // Valve image for a given step; everything closed and sieve off unless the step opens it.
    function automatic valves_t valve_pattern(input state_t s, input logic [1:0] ph,
                                              input logic [3:0] m);
        valves_t v;
        v.cells_in    = 4'hF;
        v.cells_out   = 4'hF;
        v.collect     = 4'hF;
        v.lysis_in    = 1'b1;
        v.lysis_waste = 1'b1;
        v.beads_in    = 1'b1;
        v.bead_waste  = 1'b1;
        v.push        = 1'b1;
        v.sep         = 1'b1;
        v.sieve       = 1'b0;
        v.waste       = 1'b1;
        v.pumps       = 3'b111;
        case (s)
            LOAD_CELLS: begin
                v.cells_in = ~m;
                v.pumps    = pump_rotation(ph);
            end
            LOAD_LYSIS: begin
                v.lysis_in    = 1'b0;
                v.lysis_waste = 1'b0;
                v.pumps       = 3'b000;
            end
            MIX: begin
                v.pumps = pump_rotation(ph);
            end
            LOAD_BEADS: begin
                v.beads_in   = 1'b0;
                v.bead_waste = 1'b0;
            end
            CAPTURE: begin
                v.sep   = 1'b0;
                v.pumps = pump_rotation(ph);
            end
            WASH: begin
                v.push  = 1'b0;
                v.sep   = 1'b0;
                v.waste = 1'b0;
                v.sieve = 1'b1;
            end
            ELUTE: begin
                v.push    = 1'b0;
                v.sep     = 1'b0;
                v.collect = ~m;
            end
            default: ;
        endcase
        return v;
    endfunction

`ifdef MRNAISO_SEQ_PAUSE_EN
    assign hold = bus.pause && busy_r;
`else
    assign hold = 1'b0;
`endif

    // MIX ends on a full rotation boundary rather than on the tick counter, so it
    // cannot overflow for long mixes.
    assign pump_wrap   = (pump_cnt == PUMP_TICKS - 16'd1);
    assign phase_next  = pump_wrap ? ((phase == 2'd2) ? 2'd0 : phase + 2'd1) : phase;
    assign step_last   = (state == MIX)
                       ? (pump_wrap && (phase == 2'd2) && (rot_cnt == MIX_CYCLES - 16'd1))
                       : (tick_cnt == STEP_TICKS - 16'd1);
    assign state_after = (state == ELUTE) ? IDLE : state_t'(state + 3'd1);

    // Sequencer core: state, counters and the registered valve image move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            valves   <= valve_pattern(IDLE, 2'd0, 4'd0);
            tick_cnt <= 16'd0;
            pump_cnt <= 16'd0;
            rot_cnt  <= 16'd0;
            phase    <= 2'd0;
            mask     <= 4'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (bus.abort) begin
            state    <= IDLE;
            valves   <= valve_pattern(IDLE, 2'd0, 4'd0);
            tick_cnt <= 16'd0;
            pump_cnt <= 16'd0;
            rot_cnt  <= 16'd0;
            phase    <= 2'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else if (!hold) begin
            done_r <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    if (bus.lane_mask != 4'd0) begin
                        mask     <= bus.lane_mask;
                        state    <= LOAD_CELLS;
                        busy_r   <= 1'b1;
                        valves   <= valve_pattern(LOAD_CELLS, 2'd0, bus.lane_mask);
                        tick_cnt <= 16'd0;
                        pump_cnt <= 16'd0;
                        rot_cnt  <= 16'd0;
                        phase    <= 2'd0;
                    end else begin
                        done_r <= 1'b1;
                    end
                end
            end else if (step_last) begin
                state    <= state_after;
                valves   <= valve_pattern(state_after, 2'd0, mask);
                tick_cnt <= 16'd0;
                pump_cnt <= 16'd0;
                rot_cnt  <= 16'd0;
                phase    <= 2'd0;
                if (state_after == IDLE) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
                pump_cnt <= pump_wrap ? 16'd0 : pump_cnt + 16'd1;
                phase    <= phase_next;
                if (pump_wrap && (phase == 2'd2)) begin
                    rot_cnt <= rot_cnt + 16'd1;
                end
                valves   <= valve_pattern(state, phase_next, mask);
            end
        end
    end

    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.step            = state;
    assign bus.cells_in_ctl    = valves.cells_in;
    assign bus.cells_out_ctl   = valves.cells_out;
    assign bus.collect_ctl     = valves.collect;
    assign bus.lysis_in_ctl    = valves.lysis_in;
    assign bus.lysis_waste_ctl = valves.lysis_waste;
    assign bus.beads_in_ctl    = valves.beads_in;
    assign bus.bead_waste_ctl  = valves.bead_waste;
    assign bus.push_ctl        = valves.push;
    assign bus.sep_ctl         = valves.sep;
    assign bus.sieve_ctl       = valves.sieve;
    assign bus.waste_ctl       = valves.waste;
    assign bus.pump_1          = valves.pumps[2];
    assign bus.pump_2          = valves.pumps[1];
    assign bus.pump_3          = valves.pumps[0];

endmodule

// File: tb/tb_mrna_iso_valve_sequencer.sv
// Self-checking bench for mrna_iso_valve_sequencer using a time-offset reference model.
// Pause scenario is exercised only when MRNAISO_SEQ_PAUSE_EN is defined.
module tb_mrna_iso_valve_sequencer;

    localparam int S     = 4;
    localparam int P     = 2;
    localparam int M     = 3;
    localparam int MIXL  = 3 * P * M;
    localparam int N     = 6 * S + MIXL;

    logic clk;
    logic rst;
    int   assert_count;
    int   fail_count;

    mrna_iso_valve_sequencer_if bus ();

    mrna_iso_valve_sequencer #(
        .STEP_TICKS (16'(S)),
        .PUMP_TICKS (16'(P)),
        .MIX_CYCLES (16'(M))
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [27:0] obs;
    assign obs = {bus.busy, bus.done, bus.step,
                  bus.cells_in_ctl, bus.cells_out_ctl, bus.collect_ctl,
                  bus.lysis_in_ctl, bus.lysis_waste_ctl, bus.beads_in_ctl, bus.bead_waste_ctl,
                  bus.push_ctl, bus.sep_ctl, bus.sieve_ctl, bus.waste_ctl,
                  bus.pump_1, bus.pump_2, bus.pump_3};

    // Idle image: everything pressurised, sieve off, pumps closed.
    function automatic logic [27:0] idle_vec(input logic d);
        return {1'b0, d, 3'd0, 4'hF, 4'hF, 4'hF,
                1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'b111};
    endfunction

    function automatic logic [2:0] rot(input int off);
        case ((off / P) % 3)
            0:       return 3'b011;
            1:       return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    // Expected outputs t cycles after the start-accepting edge, from the step timeline.
    function automatic logic [27:0] expected_run(input int t, input logic [3:0] m);
        logic [2:0] st;
        int         off;
        int         r;
        logic [3:0] ci  = 4'hF;
        logic [3:0] col = 4'hF;
        logic       li = 1'b1, lw = 1'b1, bi = 1'b1, bw = 1'b1;
        logic       pu = 1'b1, se = 1'b1, si = 1'b0, wa = 1'b1;
        logic [2:0] pm = 3'b111;
        if (t >= N) return idle_vec(1'b1);
        if (t < S) begin
            st = 3'd1; off = t;
        end else if (t < 2 * S) begin
            st = 3'd2; off = t - S;
        end else if (t < 2 * S + MIXL) begin
            st = 3'd3; off = t - 2 * S;
        end else begin
            r   = t - 2 * S - MIXL;
            st  = 3'(4 + r / S);
            off = r % S;
        end
        case (st)
            3'd1: begin ci = ~m; pm = rot(off); end
            3'd2: begin li = 1'b0; lw = 1'b0; pm = 3'b000; end
            3'd3: pm = rot(off);
            3'd4: begin bi = 1'b0; bw = 1'b0; end
            3'd5: begin se = 1'b0; pm = rot(off); end
            3'd6: begin pu = 1'b0; se = 1'b0; wa = 1'b0; si = 1'b1; end
            default: begin pu = 1'b0; se = 1'b0; col = ~m; end
        endcase
        return {1'b1, 1'b0, st, ci, 4'hF, col, li, lw, bi, bw, pu, se, si, wa, pm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [27:0] exp);
        assert_count++;
        assert (obs === exp)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One run from start; optional abort, ignored restart and pause at given offsets.
    task automatic apply_stimulus(input logic [3:0] m, input int abort_at,
                                  input int ignore_at, input int pause_at,
                                  input int pause_len);
        bus.lane_mask = m;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.lane_mask = 4'($urandom);
        for (int t = 0; t <= N; t++) begin
            check_output($sformatf("run m=%b t=%0d", m, t), expected_run(t, m));
            if (t == abort_at) begin
                bus.abort = 1'b1;
                tick();
                bus.abort = 1'b0;
                check_output("abort next cycle", idle_vec(1'b0));
                tick();
                check_output("abort no done", idle_vec(1'b0));
                return;
            end
            if (t == ignore_at) begin
                bus.start     = 1'b1;
                bus.lane_mask = ~m;
            end
`ifdef MRNAISO_SEQ_PAUSE_EN
            if (t == pause_at) begin
                bus.pause = 1'b1;
                for (int i = 0; i < pause_len; i++) begin
                    tick();
                    check_output($sformatf("pause t=%0d i=%0d", t, i), expected_run(t, m));
                end
                bus.pause = 1'b0;
            end
`endif
            if (t == N) break;
            tick();
            bus.start = 1'b0;
        end
        tick();
        check_output("post done", idle_vec(1'b0));
    endtask

    initial begin
        assert_count  = 0;
        fail_count    = 0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.lane_mask = 4'd0;
`ifdef MRNAISO_SEQ_PAUSE_EN
        bus.pause     = 1'b0;
`endif
        #12;
        check_output("reset", idle_vec(1'b0));
        tick();
        rst = 1'b0;
        tick();
        check_output("after reset", idle_vec(1'b0));

        $display("[TB] empty mask");
        bus.lane_mask = 4'd0;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        check_output("empty done", idle_vec(1'b1));
        tick();
        check_output("empty after", idle_vec(1'b0));

        $display("[TB] full run 0101");
        apply_stimulus(4'b0101, -1, -1, -1, 0);

        $display("[TB] abort in MIX tick 7");
        apply_stimulus(4'($urandom_range(1, 15)), 2 * S + 7, -1, -1, 0);
        apply_stimulus(4'($urandom_range(1, 15)), -1, -1, -1, 0);

        $display("[TB] ignored start");
        apply_stimulus(4'b1111, -1, 10, -1, 0);

        $display("[TB] abort beats start in idle");
        bus.lane_mask = 4'b0011;
        bus.start     = 1'b1;
        bus.abort     = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        check_output("abort over start", idle_vec(1'b0));

        $display("[TB] mid-run reset");
        bus.lane_mask = 4'b0110;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
        repeat (5) tick();
        check_output("before mid reset", expected_run(5, 4'b0110));
        #2 rst = 1'b1;
        #1;
        check_output("mid reset async", idle_vec(1'b0));
        tick();
        rst = 1'b0;
        tick();
        check_output("mid reset release", idle_vec(1'b0));

        $display("[TB] random runs");
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            apply_stimulus(4'($urandom_range(1, 15)), -1, -1, -1, 0);
        end

`ifdef MRNAISO_SEQ_PAUSE_EN
        $display("[TB] pause during WASH");
        apply_stimulus(4'b0101, -1, -1, 4 * S + MIXL + 1, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
